// File: rtl/cp0_param_if.sv
// CP0 access bundle between the MEM stage (master) and the coprocessor (slave).
// Carries MTC0/MFC0 traffic, exception/interrupt inputs and the redirect outputs.
interface cp0_param_if #(
   parameter int NUM_HWINT = 6
);
   logic                 we;
   logic [4:0]           rd_addr;
   logic [4:0]           wr_addr;
   logic [31:0]          din;
   logic [31:0]          dout;
   logic [31:0]          pc;
   logic                 bd;
   logic [4:0]           exc_code_in;
   logic [NUM_HWINT-1:0] hw_int;
   logic                 exl_clr;
   logic                 req;
   logic [31:0]          epc_out;

   modport master (
      output we, rd_addr, wr_addr, din, pc, bd, exc_code_in, hw_int, exl_clr,
      input  dout, req, epc_out
   );

   modport slave (
      input  we, rd_addr, wr_addr, din, pc, bd, exc_code_in, hw_int, exl_clr,
      output dout, req, epc_out
   );
endinterface

// File: rtl/cp0_param.sv
// Parametrised System Control Coprocessor (CP0) for the MEM stage.
// Holds SR, Cause, EPC and PRId, arbitrates hardware interrupts against
// pipeline exceptions and raises a single take-exception request.
// NUM_HWINT must be 1..6 and match the interface width; INT_SYNC_STAGES 0..2.
// Optional Count/Compare timer is enabled by defining CP0_TIMER_EN.
module cp0_param #(
   parameter int          NUM_HWINT       = 6,
   parameter int          INT_SYNC_STAGES = 0,
   parameter logic [31:0] PRID            = 32'h0000_4C50
) (
   input  logic           clk,
   input  logic           reset,
   cp0_param_if.slave     bus
);
   localparam logic [4:0] REG_COUNT   = 5'd9;
   localparam logic [4:0] REG_COMPARE = 5'd11;
   localparam logic [4:0] REG_SR      = 5'd12;
   localparam logic [4:0] REG_CAUSE   = 5'd13;
   localparam logic [4:0] REG_EPC     = 5'd14;
   localparam logic [4:0] REG_PRID    = 5'd15;

   logic [NUM_HWINT-1:0] im_reg;
   logic                 exl_reg;
   logic                 ie_reg;
   logic                 bd_reg;
   logic [4:0]           exc_code_reg;
   logic [31:0]          epc_reg;

   logic [NUM_HWINT-1:0] ip_hw;
   logic [NUM_HWINT-1:0] ip_eff;
   logic                 ti_eff;
   logic [31:0]          count_val;
   logic [31:0]          compare_val;
   logic                 int_pend;
   logic                 exc_pend;
   logic                 take_req;
   logic                 mtc0_ok;
   logic [31:0]          pc_al;
   logic [31:0]          din_al;

   assign pc_al   = {bus.pc[31:2], 2'b00};
   assign din_al  = {bus.din[31:2], 2'b00};

   // ---------------------------------------------------------------------
   // Interrupt input synchronizer: 0 stages passes hw_int straight through.
   // ---------------------------------------------------------------------
   generate
      if (INT_SYNC_STAGES == 0) begin : g_nosync
         assign ip_hw = bus.hw_int;
      end else begin : g_sync
         logic [INT_SYNC_STAGES*NUM_HWINT-1:0] sync_reg;
         logic [INT_SYNC_STAGES*NUM_HWINT-1:0] sync_next;

         assign sync_next[NUM_HWINT-1:0] = bus.hw_int;
         for (genvar gi = 1; gi < INT_SYNC_STAGES; gi++) begin : g_stage
            assign sync_next[gi*NUM_HWINT +: NUM_HWINT] =
               sync_reg[(gi-1)*NUM_HWINT +: NUM_HWINT];
         end

         // Shift the interrupt lines one stage per cycle.
         always_ff @(posedge clk) begin
            if (reset) begin
               sync_reg <= '0;
            end else begin
               sync_reg <= sync_next;
            end
         end

         assign ip_hw = sync_reg[(INT_SYNC_STAGES-1)*NUM_HWINT +: NUM_HWINT];
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Optional Count/Compare timer.
   // ---------------------------------------------------------------------
`ifdef CP0_TIMER_EN
   logic [31:0] count_reg;
   logic [31:0] compare_reg;
   logic        ti_reg;

   // TI is visible in the same cycle the match happens, then held sticky.
   assign ti_eff      = ti_reg | ((count_reg == compare_reg) && (compare_reg != 32'd0));
   assign count_val   = count_reg;
   assign compare_val = compare_reg;

   // Free-running counter, Compare register and sticky timer interrupt.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg   <= 32'd0;
         compare_reg <= 32'd0;
         ti_reg      <= 1'b0;
      end else begin
         if (mtc0_ok && bus.wr_addr == REG_COUNT) begin
            count_reg <= bus.din;
         end else begin
            count_reg <= count_reg + 32'd1;
         end
         if (mtc0_ok && bus.wr_addr == REG_COMPARE) begin
            compare_reg <= bus.din;
            ti_reg      <= 1'b0;
         end else begin
            ti_reg      <= ti_eff;
         end
      end
   end
`else
   assign ti_eff      = 1'b0;
   assign count_val   = 32'd0;
   assign compare_val = 32'd0;
`endif

   // Merge timer interrupt into the highest hardware interrupt line.
   always_comb begin
      ip_eff                = ip_hw;
      ip_eff[NUM_HWINT-1]   = ip_hw[NUM_HWINT-1] | ti_eff;
   end

   // ---------------------------------------------------------------------
   // Arbitration: interrupts win over exceptions; EXL masks both.
   // ---------------------------------------------------------------------
   assign int_pend = (|(ip_eff & im_reg)) & ie_reg & ~exl_reg;
   assign exc_pend = (bus.exc_code_in != 5'd0) & ~exl_reg;
   assign take_req = int_pend | exc_pend;
   assign mtc0_ok  = bus.we & ~take_req;
   assign bus.req  = take_req;

   // EPC forwarding lets an ERET right behind MTC0 EPC use the new value.
   assign bus.epc_out = (mtc0_ok && bus.wr_addr == REG_EPC) ? din_al : epc_reg;

   // Architectural state update: exception entry, MTC0 writes, ERET clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         im_reg       <= '0;
         exl_reg      <= 1'b0;
         ie_reg       <= 1'b0;
         bd_reg       <= 1'b0;
         exc_code_reg <= 5'd0;
         epc_reg      <= 32'd0;
      end else if (take_req) begin
         exl_reg      <= 1'b1;
         bd_reg       <= bus.bd;
         exc_code_reg <= int_pend ? 5'd0 : bus.exc_code_in;
         epc_reg      <= bus.bd ? (pc_al - 32'd4) : pc_al;
      end else begin
         if (bus.we && bus.wr_addr == REG_SR) begin
            im_reg  <= bus.din[10 +: NUM_HWINT];
            exl_reg <= bus.din[1];
            ie_reg  <= bus.din[0];
         end
         if (bus.we && bus.wr_addr == REG_EPC) begin
            epc_reg <= din_al;
         end
         // ERET clear takes precedence over an EXL value written by MTC0.
         if (bus.exl_clr) begin
            exl_reg <= 1'b0;
         end
      end
   end

   // MFC0 read mux over the pre-edge register state.
   always_comb begin
      logic [31:0] sr_val;
      logic [31:0] cause_val;
      sr_val                        = 32'd0;
      sr_val[10 +: NUM_HWINT]       = im_reg;
      sr_val[1]                     = exl_reg;
      sr_val[0]                     = ie_reg;
      cause_val                     = 32'd0;
      cause_val[31]                 = bd_reg;
      cause_val[30]                 = ti_eff;
      cause_val[10 +: NUM_HWINT]    = ip_eff;
      cause_val[6:2]                = exc_code_reg;
      case (bus.rd_addr)
         REG_COUNT:   bus.dout = count_val;
         REG_COMPARE: bus.dout = compare_val;
         REG_SR:      bus.dout = sr_val;
         REG_CAUSE:   bus.dout = cause_val;
         REG_EPC:     bus.dout = epc_reg;
         REG_PRID:    bus.dout = PRID;
         default:     bus.dout = 32'd0;
      endcase
   end
endmodule

// File: tb/tb_cp0_param.sv
// Testbench for cp0_param: two instances (6 lines/no sync, 4 lines/2-stage
// sync) share stimulus and are each compared against a rule-level model.
module tb_cp0_param;
   localparam logic [31:0] PRID = 32'h0000_4C50;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        s_we, s_bd, s_clr;
   logic [4:0]  s_rd, s_wr, s_exc;
   logic [31:0] s_din, s_pc;
   logic [5:0]  s_hw;

   cp0_param_if #(.NUM_HWINT(6)) bus_a ();
   cp0_param_if #(.NUM_HWINT(4)) bus_b ();

   assign bus_a.we = s_we;   assign bus_b.we = s_we;
   assign bus_a.rd_addr = s_rd;   assign bus_b.rd_addr = s_rd;
   assign bus_a.wr_addr = s_wr;   assign bus_b.wr_addr = s_wr;
   assign bus_a.din = s_din; assign bus_b.din = s_din;
   assign bus_a.pc = s_pc;   assign bus_b.pc = s_pc;
   assign bus_a.bd = s_bd;   assign bus_b.bd = s_bd;
   assign bus_a.exc_code_in = s_exc;  assign bus_b.exc_code_in = s_exc;
   assign bus_a.hw_int = s_hw;        assign bus_b.hw_int = s_hw[3:0];
   assign bus_a.exl_clr = s_clr;      assign bus_b.exl_clr = s_clr;

   cp0_param #(.NUM_HWINT(6), .INT_SYNC_STAGES(0), .PRID(PRID)) dut_a (
      .clk(clk), .reset(reset), .bus(bus_a));
   cp0_param #(.NUM_HWINT(4), .INT_SYNC_STAGES(2), .PRID(PRID)) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b));

   // ---------------- reference model (index 0 = dut_a, 1 = dut_b) ----------
   int          n_hw   [2] = '{6, 4};
   int          n_sync [2] = '{0, 2};
   logic [5:0]  m_im [2];
   logic        m_exl [2], m_ie [2], m_bd [2], m_ti [2];
   logic [4:0]  m_exc [2];
   logic [31:0] m_epc [2], m_cnt [2], m_cmp [2];
   logic [5:0]  m_h0 [2], m_h1 [2];   // hw_int seen 1 and 2 edges ago

   int n_assert = 0;
   int n_fail   = 0;

   function automatic logic [5:0] hw_mask(int k);
      return 6'((1 << n_hw[k]) - 1);
   endfunction

   function automatic logic m_ti_eff(int k);
`ifdef CP0_TIMER_EN
      return m_ti[k] | ((m_cnt[k] == m_cmp[k]) && (m_cmp[k] != 0));
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [5:0] m_ip(int k);
      logic [5:0] v;
      if (n_sync[k] == 0)      v = s_hw & hw_mask(k);
      else if (n_sync[k] == 1) v = m_h0[k];
      else                     v = m_h1[k];
      if (m_ti_eff(k)) v[n_hw[k]-1] = 1'b1;
      return v;
   endfunction

   function automatic logic m_int_pend(int k);
      return ((m_ip(k) & m_im[k]) != 0) && m_ie[k] && !m_exl[k];
   endfunction

   function automatic logic m_req(int k);
      return m_int_pend(k) || ((s_exc != 0) && !m_exl[k]);
   endfunction

   function automatic logic [31:0] m_read(int k, logic [4:0] a);
      case (a)
`ifdef CP0_TIMER_EN
         5'd9:  return m_cnt[k];
         5'd11: return m_cmp[k];
`endif
         5'd12: return (32'(m_im[k]) << 10) | (32'(m_exl[k]) << 1) | 32'(m_ie[k]);
         5'd13: return (32'(m_bd[k]) << 31) | (32'(m_ti_eff(k)) << 30) |
                       (32'(m_ip(k)) << 10) | (32'(m_exc[k]) << 2);
         5'd14: return m_epc[k];
         5'd15: return PRID;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] m_epc_out(int k);
      if (s_we && s_wr == 5'd14 && !m_req(k)) return s_din & ~32'h3;
      return m_epc[k];
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 2; k++) begin
         m_im[k] = 0; m_exl[k] = 0; m_ie[k] = 0; m_bd[k] = 0; m_ti[k] = 0;
         m_exc[k] = 0; m_epc[k] = 0; m_cnt[k] = 0; m_cmp[k] = 0;
         m_h0[k] = 0; m_h1[k] = 0;
      end
   endtask

   // Apply one clock edge worth of architectural rules to model k.
   task automatic model_update(int k);
      logic rq, ip_pend, tie;
      rq = m_req(k); ip_pend = m_int_pend(k); tie = m_ti_eff(k);
      m_h1[k] = m_h0[k];
      m_h0[k] = s_hw & hw_mask(k);
      if (!rq && s_we && s_wr == 5'd9) m_cnt[k] = s_din;
      else                             m_cnt[k] = m_cnt[k] + 1;
      if (!rq && s_we && s_wr == 5'd11) begin
         m_cmp[k] = s_din; m_ti[k] = 1'b0;
      end else begin
         m_ti[k] = tie;
      end
      if (rq) begin
         m_exl[k] = 1'b1;
         m_bd[k]  = s_bd;
         m_exc[k] = ip_pend ? 5'd0 : s_exc;
         m_epc[k] = (s_pc & ~32'h3) - (s_bd ? 32'd4 : 32'd0);
      end else begin
         if (s_we && s_wr == 5'd12) begin
            m_im[k]  = (s_din[15:10]) & hw_mask(k);
            m_exl[k] = s_din[1];
            m_ie[k]  = s_din[0];
         end
         if (s_we && s_wr == 5'd14) m_epc[k] = s_din & ~32'h3;
         if (s_clr) m_exl[k] = 1'b0;
      end
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One cycle: compare all outputs of both DUTs against the model, then clock.
   task automatic step(string tag);
      #2;
      chk({tag, "/a.req"},  32'(bus_a.req),  32'(m_req(0)));
      chk({tag, "/a.dout"}, bus_a.dout,      m_read(0, s_rd));
      chk({tag, "/a.epc"},  bus_a.epc_out,   m_epc_out(0));
      chk({tag, "/b.req"},  32'(bus_b.req),  32'(m_req(1)));
      chk({tag, "/b.dout"}, bus_b.dout,      m_read(1, s_rd));
      chk({tag, "/b.epc"},  bus_b.epc_out,   m_epc_out(1));
      $display("step %-8s rst=%0b we=%0b wr=%0d din=%h rd=%0d exc=%0d hw=%h clr=%0b | a.req=%0b a.dout=%h b.req=%0b b.dout=%h",
               tag, reset, s_we, s_wr, s_din, s_rd, s_exc, s_hw, s_clr,
               bus_a.req, bus_a.dout, bus_b.req, bus_b.dout);
      if (reset) model_clear();
      else for (int k = 0; k < 2; k++) model_update(k);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      s_we = 0; s_clr = 0; s_exc = 0; s_bd = 0;
   endtask

   initial begin
      logic [4:0]  addrs [4];
      logic [31:0] exps  [4];
      logic [4:0]  wr_pick [8];
      addrs = '{5'd12, 5'd13, 5'd14, 5'd15};
      exps  = '{32'd0, 32'd0, 32'd0, PRID};
      wr_pick = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0, 5'd3};

      reset = 1; s_we = 0; s_rd = 0; s_wr = 0; s_din = 0; s_pc = 0;
      s_bd = 0; s_exc = 0; s_hw = 0; s_clr = 0;
      repeat (2) @(posedge clk);
      #1;
      reset = 0;
      model_clear();

      // Reset values.
      for (int i = 0; i < 4; i++) begin
         s_rd = addrs[i];
         #1 chk("reset_read", bus_a.dout, exps[i]);
         chk("reset_req", 32'(bus_a.req), 32'd0);
         step("rst_rd");
      end

      // Interrupt on line 0.
      s_we = 1; s_wr = 12; s_din = 32'h0000_0401; s_rd = 12;
      step("wr_sr");
      s_we = 0; s_hw = 6'h01; s_pc = 32'h0000_3010; s_bd = 0;
      #1 chk("int_req", 32'(bus_a.req), 32'd1);
      step("int");
      s_hw = 0; s_rd = 14;
      #1 chk("int_epc", bus_a.dout, 32'h0000_3010);
      chk("int_req_off", 32'(bus_a.req), 32'd0);
      s_rd = 12;
      #1 chk("int_sr_exl", bus_a.dout, 32'h0000_0403);
      step("int_rd");
      step("idle");
      step("idle");

      // Exception in a delay slot with IE = 0.
      s_we = 1; s_wr = 12; s_din = 32'h0000_0400; s_clr = 1;
      step("sr_clr");
      idle(); s_exc = 5'd4; s_pc = 32'h0000_3024; s_bd = 1;
      #1 chk("exc_req", 32'(bus_a.req), 32'd1);
      step("exc");
      idle(); s_rd = 13;
      #1 chk("exc_cause", bus_a.dout, 32'h8000_0010);
      s_rd = 14;
      #1 chk("exc_epc", bus_a.dout, 32'h0000_3020);
      step("exc_rd");

      // EXL blocks everything until ERET.
      s_exc = 5'd12; s_hw = 6'h3F; s_we = 1; s_wr = 12; s_din = 32'h0000_FC03;
      #1 chk("exl_block0", 32'(bus_a.req), 32'd0);
      step("exl_blk");
      s_we = 0;
      #1 chk("exl_block1", 32'(bus_a.req), 32'd0);
      step("exl_blk");
      s_exc = 0; s_clr = 1;
      #1 chk("eret_req", 32'(bus_a.req), 32'd0);
      step("eret");
      s_clr = 0; s_rd = 12;
      #1 chk("eret_sr", bus_a.dout, 32'h0000_FC01);
      chk("eret_int", 32'(bus_a.req), 32'd1);
      step("eret_int");

      // MTC0 EPC forwarding alongside ERET.
      s_hw = 0; s_we = 1; s_wr = 14; s_din = 32'h0000_4007; s_clr = 1;
      #1 chk("epc_fwd", bus_a.epc_out, 32'h0000_4004);
      chk("epc_fwd_req", 32'(bus_a.req), 32'd0);
      step("epc_fwd");
      idle(); s_rd = 14;
      #1 chk("epc_reg", bus_a.dout, 32'h0000_4004);
      step("epc_rd");

      // Two-stage synchronizer latency on dut_b.
      repeat (3) step("settle");
      s_we = 1; s_wr = 12; s_din = 32'h0000_FC01; s_clr = 1;
      step("sr_arm");
      idle(); s_hw = 6'h02; s_rd = 13;
      #1 chk("sync_n0", 32'(bus_b.req), 32'd0);
      step("sync_n0");
      #1 chk("sync_n1", 32'(bus_b.req), 32'd0);
      step("sync_n1");
      #1 chk("sync_n2", 32'(bus_b.req), 32'd1);
      chk("sync_ip11", 32'(bus_b.dout[11]), 32'd1);
      step("sync_n2");
      s_hw = 0;

`ifdef CP0_TIMER_EN
      // Compare = 5 straight after reset; the model tracks when TI fires.
      reset = 1; step("t_rst");
      reset = 0; s_we = 1; s_wr = 11; s_din = 32'd5; s_rd = 13;
      step("t_cmp");
      s_we = 1; s_wr = 12; s_din = 32'h0000_FC01;
      step("t_sr");
      s_we = 0;
      repeat (6) step("t_run");
      s_we = 1; s_wr = 11; s_din = 32'd0;
      step("t_clr");
      s_we = 0;
      step("t_run");
`endif

      // Randomized phase.
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(99) == 0);
         s_we  = ($urandom_range(9) < 3);
         s_wr  = wr_pick[$urandom_range(7)];
         s_din = $urandom;
         if ($urandom_range(3) == 0) s_din[1] = 1'b0;
         s_rd  = 5'($urandom_range(31) < 24 ? $urandom_range(15) : $urandom_range(31));
         s_pc  = $urandom;
         s_bd  = 1'($urandom_range(1));
         s_exc = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : 5'd0;
         if ($urandom_range(4) == 0) s_hw = 6'($urandom_range(63));
         s_clr = ($urandom_range(6) == 0);
         step("rand");
      end
      reset = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/cp0_param.md
Name: cp0_param

Overview:
- Parametrised System Control Coprocessor (CP0) for the 5-stage MIPS pipeline, instantiated in the MEM stage.
- Owns SR, Cause, EPC and PRId.
- Arbitrates hardware interrupts against pipeline-reported exceptions and raises a single take-exception request that flushes the pipeline and redirects NPC.
- Generalises the fixed 6-line CP0: configurable interrupt count, configurable synchronizer depth on interrupt inputs, and EPC write forwarding for ERET.

Parameters:
- NUM_HWINT, 6, number of hardware interrupt lines (1..6); mapped to SR.IM and Cause.IP bits [10+NUM_HWINT-1:10].
- INT_SYNC_STAGES, 0, register stages on hw_int before Cause.IP (0..2).
- PRID, 32'h0000_4C50, read-only PRId value.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- we  in  1  MTC0 write enable
- rd_addr  in  5  CP0 read register number
- wr_addr  in  5  CP0 write register number
- din  in  32  MTC0 write data
- dout  out  32  MFC0 read data (combinational)
- pc  in  32  PC of instruction in MEM stage
- bd  in  1  MEM instruction is in a branch delay slot
- exc_code_in  in  5  exception code from pipeline; 0 = none
- hw_int  in  NUM_HWINT  hardware interrupt requests, level sensitive
- exl_clr  in  1  ERET retiring, clears SR.EXL
- req  out  1  take interrupt/exception this cycle (combinational)
- epc_out  out  32  EPC for ERET redirect

Behaviour:
- Single clock; reset is synchronous and active-high. On reset:
  - SR = 0, Cause = 0, EPC = 0, synchronizer stages = 0.
  - Consequences: req = 0, dout = 0 (rd_addr = 0), epc_out = 0.
- Register map:
  - 12 SR: IM at [10+NUM_HWINT-1:10], EXL bit 1, IE bit 0; all other bits read 0.
  - 13 Cause: BD bit 31, IP at [10+NUM_HWINT-1:10], ExcCode [6:2]; all others 0.
  - 14 EPC.
  - 15 PRId = PRID.
  - All other addresses read 0.
- Cause.IP is refreshed every cycle from hw_int after INT_SYNC_STAGES flops (latency 0..2 cycles). It is not writable.
- int_pend = |(IP & IM) & IE & !EXL.
- exc_pend = (exc_code_in != 0) & !EXL.
- req = int_pend | exc_pend. Interrupt has priority over exception.
- On a clock edge with req = 1:
  - EXL <= 1.
  - BD <= bd.
  - ExcCode <= 0 if int_pend, else exc_code_in.
  - EPC <= bd ? {pc[31:2],2'b00} - 4 : {pc[31:2],2'b00}.
  - Any MTC0 in the same cycle is discarded.
  - exl_clr in the same cycle is ignored (req wins).
- MTC0 (we = 1, req = 0):
  - SR: writes IM, EXL, IE only.
  - EPC: writes {din[31:2],2'b00}.
  - Cause, PRId, unmapped: no effect.
- exl_clr = 1 with req = 0: EXL <= 0 next edge. If the same cycle also carries an MTC0 to SR, exl_clr overrides the written EXL bit.
- epc_out = (we & wr_addr == 14 & !req) ? {din[31:2],2'b00} : EPC. This forwarding lets ERET immediately after MTC0 EPC redirect correctly.
- dout reflects register state before the current edge. There is no read-during-write bypass.
- hw_int width mismatch is not allowed; NUM_HWINT outside 1..6 is illegal.

Optional Feature:
- Macro CP0_TIMER_EN.
- When defined:
  - Count (reg 9) increments by 1 every cycle, wrapping at 2^32.
  - Compare (reg 11) is writable.
  - When Count == Compare and Compare != 0, TI (Cause bit 30) is set.
  - TI is ORed into IP[10+NUM_HWINT-1] before masking.
  - Any MTC0 to Compare clears TI.
  - MTC0 to Count loads din; when Count is written, that write replaces the increment for that cycle.
  - Count and Compare reset to 0.
- When undefined: regs 9/11 read 0, writes are ignored, Cause bit 30 reads 0.

Test Plan:
- Reset, then read 12/13/14/15 -> 0, 0, 0, 32'h0000_4C50; req = 0.
- MTC0 SR = 32'h0000_0401, hw_int[0] = 1 (INT_SYNC_STAGES = 0), pc = 32'h0000_3010, bd = 0 -> req = 1 same cycle; next cycle EPC = 32'h3010, ExcCode = 0, EXL = 1, req = 0.
- exc_code_in = 5'd4, pc = 32'h3024, bd = 1, SR.IE = 0 -> req = 1; EPC = 32'h3020, Cause = 32'h8000_0010.
- EXL = 1 with exc_code_in = 12 and hw_int all ones -> req stays 0; then exl_clr -> EXL = 0 next cycle; pending interrupt with IE = 1 and IM set raises req the following cycle.
- MTC0 EPC = 32'h0000_4007 with exl_clr in the same cycle -> epc_out = 32'h4004 combinationally; EPC = 32'h4004 after the edge.
- INT_SYNC_STAGES = 2, hw_int[1] rises at cycle n -> IP bit 11 and req assert at cycle n+2.
- With CP0_TIMER_EN: write Compare = 5 right after reset -> req at Count = 5, with ExcCode 0 and Cause bit 30 = 1; rewriting Compare clears bit 30.
